// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: sequential packed-BCD to unsigned binary converter.
// Reverse double dabble: one right-shift-and-correct step per clock, BIN_W steps per conversion.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - conversion request, sampled only while idle
//   bcd    - packed BCD input, digit 0 (ones) in bits [3:0]
//   bin    - registered result, held between conversions
//   busy   - high while a conversion is in progress
//   done   - one-cycle pulse when bin/err are updated
//   err    - last accepted request had a digit > 9; sticky until the next accepted start
module bcd_to_binary_seq #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam logic [CntW-1:0] LastStep = CntW'(BIN_W - 1);

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   sbcd_q, sbcd_d;
  logic [BIN_W-1:0]  sbin_q, sbin_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [BcdW-1:0]   shift_bcd;
  logic [BIN_W-1:0]  shift_bin;
  logic [BcdW-1:0]   corr_bcd;
  logic              bad_digit;

  // One step: shift the concatenated register right, then pull every digit >= 8 back by 3.
  always_comb begin
    {shift_bcd, shift_bin} = {1'b0, sbcd_q, sbin_q[BIN_W-1:1]};
    corr_bcd = shift_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (shift_bcd[4*i +: 4] >= 4'd8) begin
        corr_bcd[4*i +: 4] = shift_bcd[4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sbcd_d  = sbcd_q;
    sbin_d  = sbin_q;
    bin_d   = bin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (bad_digit) begin
            // Rejected request: report and stay idle, bin untouched.
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            sbcd_d  = bcd;
            sbin_d  = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = StConv;
          end
        end
      end
      StConv: begin
        sbcd_d = corr_bcd;
        sbin_d = shift_bin;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastStep) begin
          bin_d   = shift_bin;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sbcd_q  <= '0;
      sbin_q  <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sbcd_q  <= sbcd_d;
      sbin_q  <= sbin_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bin  = bin_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb_bcd_to_binary_seq: directed self-checking bench for bcd_to_binary_seq.
// Instantiates a default 3-digit converter and a 4-digit / 14-bit converter.
module tb_bcd_to_binary_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd;
  logic [9:0]  bin;
  logic        busy;
  logic        done;
  logic        err;

  logic        start4;
  logic [15:0] bcd4;
  logic [13:0] bin4;
  logic        busy4;
  logic        done4;
  logic        err4;

  int n_checks = 0;
  int n_errors = 0;

  bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bcd   (bcd),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  bcd_to_binary_seq #(.DIGITS(4), .BIN_W(14)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .bcd   (bcd4),
    .bin   (bin4),
    .busy  (busy4),
    .done  (done4),
    .err   (err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Decimal value of a packed BCD word, straight from its digits.
  function automatic int bcd_val(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  // Issue one start to the 3-digit unit and follow it to done.
  task automatic run_conv(input logic [11:0] v, input int exp_bin, input string tag);
    int cyc;
    @(negedge clk);
    bcd   = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " busy@accept"}, busy, 1);
    check({tag, " err@accept"}, err, 0);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, 10);
    check({tag, " bin"}, bin, exp_bin);
    check({tag, " busy@done"}, busy, 0);
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, done, 0);
  endtask

  task automatic run_conv4(input logic [15:0] v, input int exp_bin, input string tag);
    int cyc;
    @(negedge clk);
    bcd4   = v;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    check({tag, " busy@accept"}, busy4, 1);
    cyc = 0;
    while (!done4 && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, 14);
    check({tag, " bin"}, bin4, exp_bin);
    check({tag, " err"}, err4, 0);
  endtask

  initial begin
    int nd;
    int exp_cyc[3];
    int exp_res[3];
    logic [11:0] v;

    rst_n  = 1'b0;
    start  = 1'b0;
    bcd    = '0;
    start4 = 1'b0;
    bcd4   = '0;
    #12;
    check("reset bin", bin, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_conv(12'h999, 999, "c999");
    run_conv(12'h000, 0, "c000");
    run_conv(12'h255, 255, "c255");
    run_conv(12'h512, 512, "c512");
    run_conv(12'h001, 1, "c001");

    // Invalid digit: rejected at once, bin keeps 1.
    @(negedge clk);
    bcd   = 12'h1A3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("inv err", err, 1);
    check("inv done", done, 1);
    check("inv busy", busy, 0);
    check("inv bin", bin, 1);
    @(posedge clk);
    #1;
    check("inv done fall", done, 0);
    check("inv err sticky", err, 1);
    run_conv(12'h042, 42, "c042");

    // Held start; bcd changes at cycle 3 while the first conversion is in flight.
    exp_cyc = '{10, 21, 32};
    exp_res = '{123, 777, 777};
    nd = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      start = (c < 30);
      bcd   = (c >= 3) ? 12'h777 : 12'h123;
      @(posedge clk);
      #1;
      if (done) begin
        if (nd < 3) begin
          check("held cycle", c, exp_cyc[nd]);
          check("held bin", bin, exp_res[nd]);
        end
        nd++;
      end
    end
    check("held count", nd, 3);
    start = 1'b0;

    // Reset in the middle of a conversion.
    @(negedge clk);
    bcd   = 12'h999;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst busy", busy, 0);
    check("rst bin", bin, 0);
    check("rst done", done, 0);
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
      if (c == 2) begin
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    check("rst no done", nd, 0);
    run_conv(12'h314, 314, "c314");

    // Full sweep of valid 3-digit inputs against the decimal value.
    for (int k = 0; k < 1000; k++) begin
      v = {4'(k / 100), 4'((k / 10) % 10), 4'(k % 10)};
      run_conv(v, bcd_val({4'h0, v}), "sweep");
    end

    run_conv4(16'h9999, 9999, "w9999");
    run_conv4(16'h1234, 1234, "w1234");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
